// File: rtl/ascon_result_reader_if.sv
// Word stream from the ASCON result reader to the PS-side readback path.
// The reader drives the word, its index and the valid/last flags; the
// consumer answers with ready.
interface ascon_result_reader_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic [4:0]  word_idx;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        output word_idx,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        input  word_idx,
        output dout_ready
    );
endinterface

// File: rtl/ascon_result_reader.sv
// ASCON result reader.
// After a start request it waits LATENCY cycles for the core outputs to
// settle, snapshots ciphertext+tag and plaintext, then streams them out as
// twenty 32-bit words, most significant word first: twelve ciphertext/tag
// words followed by eight plaintext words. An all-ones plaintext is the
// core's tag-failure marker and clears auth_ok.
module ascon_result_reader #(
    parameter int LATENCY = 64,
    parameter int CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [383:0]                  i_ct_in,
    input  logic [255:0]                  i_pt_in,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_auth_ok,
    ascon_result_reader_if.master         dout_if
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST  = CNT_W'(LATENCY - 1);
    localparam logic [4:0]       LP_LAST_WORD = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM,
        ST_FIN
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [383:0]     r_snapCt;
    logic [255:0]     r_snapPt;
    logic             r_authOk;
    logic [4:0]       r_wordIdx;

    logic             w_waitDone;
    logic             w_handshake;
    logic             w_lastWord;
    logic [639:0]     w_stream;
    logic [9:0]       w_bitTop;

    // The snapshot is taken on the last WAIT edge; a handshake only counts in STREAM.
    assign w_waitDone  = (r_state == ST_WAIT) && (r_cnt == LP_CNT_LAST);
    assign w_handshake = (r_state == ST_STREAM) && dout_if.dout_ready;
    assign w_lastWord  = (r_wordIdx == LP_LAST_WORD);

    // Ciphertext+tag followed by plaintext forms one big-endian 640-bit message.
    assign w_stream = {r_snapCt, r_snapPt};
    assign w_bitTop = 10'd639 - {r_wordIdx, 5'd0};

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start only matters in IDLE, FIN always lasts one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_waitDone) begin
                    w_nextState = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_handshake && w_lastWord) begin
                    w_nextState = ST_FIN;
                end
            end
            ST_FIN: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Settle counter: held at zero while idle so every WAIT starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Snapshot of the core outputs and the authentication verdict for this run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapCt <= '0;
            r_snapPt <= '0;
            r_authOk <= 1'b0;
        end else if (w_waitDone) begin
            r_snapCt <= i_ct_in;
            r_snapPt <= i_pt_in;
            r_authOk <= (i_pt_in != '1);
        end
    end

    // Word index: advances per accepted word, parks on 19 through FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wordIdx <= '0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_waitDone) begin
                        r_wordIdx <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_handshake && !w_lastWord) begin
                        r_wordIdx <= r_wordIdx + 5'd1;
                    end
                end
                ST_FIN: begin
                    r_wordIdx <= '0;
                end
                default: begin
                    r_wordIdx <= r_wordIdx;
                end
            endcase
        end
    end

    // Status and stream outputs decoded from state and the snapshot.
    always_comb begin
        o_busy             = (r_state != ST_IDLE);
        o_done             = (r_state == ST_FIN);
        o_auth_ok          = r_authOk;
        dout_if.dout_valid = (r_state == ST_STREAM);
        dout_if.dout_last  = (r_state == ST_STREAM) && w_lastWord;
        dout_if.word_idx   = r_wordIdx;
        dout_if.dout       = w_stream[w_bitTop -: 32];
    end

endmodule

// File: tb/tb_ascon_result_reader.sv
// Testbench for ascon_result_reader with a short settle latency.
// A transaction-level model predicts every output each cycle; directed
// tests add literal expectations for capture, auth failure, backpressure,
// input changes, ignored starts and reset mid-stream.
module tb_ascon_result_reader;

    localparam int LATENCY = 4;
    localparam int CNT_W   = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [383:0] ctIn;
    logic [255:0] ptIn;
    logic         busy;
    logic         done;
    logic         authOk;

    ascon_result_reader_if dutIf ();

    ascon_result_reader #(
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start),
        .i_ct_in   (ctIn),
        .i_pt_in   (ptIn),
        .o_busy    (busy),
        .o_done    (done),
        .o_auth_ok (authOk),
        .dout_if   (dutIf)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model state: a run is "waiting", "streaming" or "finishing".
    bit          mArmed     = 0;
    int          mWaitLeft  = 0;
    bit          mStreaming = 0;
    bit          mDonePhase = 0;
    int          mIdx       = 0;
    bit          mAuth      = 0;
    logic [31:0] mWords [20];

    // Observations gathered by the monitor.
    logic [31:0] recv [$];
    int          doneCount     = 0;
    int          doneCyc       = 0;
    int          lastCyc       = 0;
    int          firstValidCyc = 0;
    logic [31:0] lastWord      = '0;
    bit          prevValid     = 0;
    bit          prevHold      = 0;
    logic [31:0] prevDout      = '0;
    logic [4:0]  prevIdx       = '0;
    logic        prevLast      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Big-endian split of the 640-bit message {ct, pt} into twenty words.
    task automatic buildWords(input logic [383:0] ct, input logic [255:0] pt, output logic [31:0] w [20]);
        logic [639:0] msg;
        msg = {ct, pt};
        for (int i = 0; i < 20; i++) begin
            w[i] = 32'(msg >> (608 - 32 * i));
        end
    endtask

    // Drive inputs for the coming edge, then return just after that edge.
    task automatic applyStimulus(input logic s, input logic r);
        start            = s;
        dutIf.dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model, advanced once per rising edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mArmed     = 1;
            mWaitLeft  = 0;
            mStreaming = 0;
            mDonePhase = 0;
            mIdx       = 0;
            mAuth      = 0;
            for (int i = 0; i < 20; i++) mWords[i] = '0;
        end else if (mArmed) begin
            if (mWaitLeft > 0) begin
                mWaitLeft--;
                if (mWaitLeft == 0) begin
                    buildWords(ctIn, ptIn, mWords);
                    mAuth      = (ptIn != '1);
                    mStreaming = 1;
                    mIdx       = 0;
                end
            end else if (mStreaming) begin
                if (dutIf.dout_ready) begin
                    if (mIdx == 19) begin
                        mStreaming = 0;
                        mDonePhase = 1;
                    end else begin
                        mIdx++;
                    end
                end
            end else if (mDonePhase) begin
                mDonePhase = 0;
                mIdx       = 0;
            end else if (start) begin
                mWaitLeft = LATENCY;
            end
        end
    end

    // Compare process and monitor, on the falling edge.
    always @(negedge clk) begin
        if (mArmed) begin
            checkOutput("busy", 32'(busy), 32'((mWaitLeft > 0) || mStreaming || mDonePhase));
            checkOutput("done", 32'(done), 32'(mDonePhase));
            checkOutput("dout_valid", 32'(dutIf.dout_valid), 32'(mStreaming));
            checkOutput("auth_ok", 32'(authOk), 32'(mAuth));
            checkOutput("word_idx", 32'(dutIf.word_idx), 32'(mIdx));
            checkOutput("dout_last", 32'(dutIf.dout_last), 32'(mStreaming && (mIdx == 19)));
            if (mStreaming) begin
                checkOutput("dout", dutIf.dout, mWords[mIdx]);
            end
            if (prevHold) begin
                checkOutput("hold_dout", dutIf.dout, prevDout);
                checkOutput("hold_idx", 32'(dutIf.word_idx), 32'(prevIdx));
                checkOutput("hold_last", 32'(dutIf.dout_last), 32'(prevLast));
            end
            if (dutIf.dout_valid && !prevValid) firstValidCyc = cyc;
            if (dutIf.dout_valid && dutIf.dout_ready && !rst) begin
                recv.push_back(dutIf.dout);
                if (dutIf.dout_last) begin
                    lastWord = dutIf.dout;
                    lastCyc  = cyc;
                end
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
            prevValid = dutIf.dout_valid;
            prevHold  = dutIf.dout_valid && !dutIf.dout_ready && !rst;
            prevDout  = dutIf.dout;
            prevIdx   = dutIf.word_idx;
            prevLast  = dutIf.dout_last;
        end
    end

    // Run until done is seen; mode 1 applies the 1,0,0,1 ready pattern.
    task automatic runUntilDone(input logic startVal, input int mode, input bit scramble);
        bit   found;
        logic r;
        found = 0;
        for (int k = 0; k < 400; k++) begin
            case (k % 4)
                1, 2:    r = (mode == 1) ? 1'b0 : 1'b1;
                default: r = 1'b1;
            endcase
            if (scramble && dutIf.dout_valid) begin
                ctIn = {12{$urandom}};
                ptIn = {8{$urandom}};
            end
            applyStimulus(startVal, r);
            if (done) begin
                found = 1;
                break;
            end
        end
        checkOutput("run_reaches_done", 32'(found), 32'd1);
    endtask

    // Compare the collected stream against an expected word list.
    task automatic checkStream(input string name, input logic [31:0] exp [20]);
        logic [31:0] act;
        checkOutput({name, "_count"}, 32'(recv.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            act = (i < recv.size()) ? recv[i] : 32'hxxxxxxxx;
            checkOutput($sformatf("%s_word%0d", name, i), act, exp[i]);
        end
    endtask

    logic [383:0] ctBase;
    logic [255:0] ptBase;
    logic [31:0]  expWords [20];
    int           startCyc;
    int           doneBefore;
    bit           reached;

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        dutIf.dout_ready = 1'b0;
        ctIn             = '0;
        ptIn             = '0;
        for (int b = 0; b < 48; b++) ctBase[383 - 8 * b -: 8] = 8'(b);
        for (int b = 0; b < 32; b++) ptBase[255 - 8 * b -: 8] = 8'(8'hA0 + b);

        // Reset state
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_dout", dutIf.dout, 32'd0);
        checkOutput("reset_valid", 32'(dutIf.dout_valid), 32'd0);
        rst = 1'b0;

        // Basic capture
        $display("[TB] basic capture");
        ctIn = ctBase;
        ptIn = ptBase;
        recv.delete();
        applyStimulus(1, 1);
        startCyc = cyc;
        runUntilDone(0, 0, 0);
        checkOutput("auth_ok_basic", 32'(authOk), 32'd1);
        applyStimulus(0, 1);
        checkOutput("first_valid_edges", 32'(firstValidCyc - startCyc + 1), 32'd5);
        checkOutput("word0", recv.size() > 0 ? recv[0] : 32'hx, 32'h00010203);
        checkOutput("word11", recv.size() > 11 ? recv[11] : 32'hx, 32'h2C2D2E2F);
        checkOutput("word12", recv.size() > 12 ? recv[12] : 32'hx, 32'hA0A1A2A3);
        checkOutput("last_word", lastWord, 32'hBCBDBEBF);
        checkOutput("done_after_last", 32'(doneCyc - lastCyc), 32'd1);
        buildWords(ctBase, ptBase, expWords);
        checkStream("basic", expWords);

        // Auth failure
        $display("[TB] auth failure");
        ptIn = '1;
        recv.delete();
        applyStimulus(1, 1);
        runUntilDone(0, 0, 0);
        checkOutput("auth_ok_fail", 32'(authOk), 32'd0);
        checkOutput("authfail_word0", recv.size() > 0 ? recv[0] : 32'hx, 32'h00010203);
        checkOutput("authfail_word11", recv.size() > 11 ? recv[11] : 32'hx, 32'h2C2D2E2F);
        for (int i = 12; i < 20; i++) begin
            checkOutput($sformatf("authfail_pt%0d", i), i < recv.size() ? recv[i] : 32'hx, 32'hFFFFFFFF);
        end
        applyStimulus(0, 1);

        // Backpressure
        $display("[TB] backpressure");
        ptIn = ptBase;
        recv.delete();
        applyStimulus(1, 1);
        runUntilDone(0, 1, 0);
        applyStimulus(0, 1);
        buildWords(ctBase, ptBase, expWords);
        checkStream("bp", expWords);

        // Inputs change after the snapshot
        $display("[TB] input change during stream");
        ctIn = ctBase;
        ptIn = ptBase;
        recv.delete();
        applyStimulus(1, 1);
        runUntilDone(0, 1, 1);
        applyStimulus(0, 1);
        checkStream("scramble", expWords);
        ctIn = ctBase;
        ptIn = ptBase;

        // Starts during WAIT, STREAM and FIN are ignored
        $display("[TB] ignored starts");
        recv.delete();
        doneBefore = doneCount;
        applyStimulus(1, 1);
        runUntilDone(1, 0, 0);
        applyStimulus(1, 1);
        checkOutput("fin_start_ignored", 32'(busy), 32'd0);
        checkOutput("one_done", 32'(doneCount - doneBefore), 32'd1);
        checkStream("ignored", expWords);
        applyStimulus(1, 1);
        checkOutput("restart_after_fin", 32'(busy), 32'd1);
        recv.delete();
        runUntilDone(0, 0, 0);
        applyStimulus(0, 1);
        checkStream("restart", expWords);

        // Reset mid-stream
        $display("[TB] reset mid-stream");
        recv.delete();
        applyStimulus(1, 1);
        reached = 0;
        for (int k = 0; k < 100; k++) begin
            if (dutIf.dout_valid && dutIf.word_idx == 5'd7) begin
                reached = 1;
                break;
            end
            applyStimulus(0, 1);
        end
        checkOutput("reach_word7", 32'(reached), 32'd1);
        doneBefore = doneCount;
        rst = 1'b1;
        applyStimulus(0, 1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_auth", 32'(authOk), 32'd0);
        checkOutput("rst_dout", dutIf.dout, 32'd0);
        checkOutput("rst_valid", 32'(dutIf.dout_valid), 32'd0);
        checkOutput("rst_last", 32'(dutIf.dout_last), 32'd0);
        checkOutput("rst_idx", 32'(dutIf.word_idx), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(0, 1);
        checkOutput("rst_no_done", 32'(doneCount - doneBefore), 32'd0);
        recv.delete();
        applyStimulus(1, 1);
        runUntilDone(0, 0, 0);
        applyStimulus(0, 1);
        checkStream("after_rst", expWords);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
